// File: rtl/rv32_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_exec_unit_pkg
//  Description : Opcode and funct3 constants shared by the RV32I execute unit
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_exec_unit_pkg;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_SYSTEM = 7'b1110011;

    // ALU funct3 for OP / OP-IMM
    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/rv32_imm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_imm_decode
//  Description : Sign-extended immediate extraction for all RV32I formats
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_imm_decode
    import rv32_exec_unit_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // Select the immediate layout from the opcode; unknown opcodes yield zero
    always_comb begin
        imm = 32'h0000_0000;
        case (inst[6:0])
            c_LOAD, c_OP_IMM, c_JALR:
                imm = {{20{inst[31]}}, inst[31:20]};
            c_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            c_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            c_LUI, c_AUIPC:
                imm = {inst[31:12], 12'h000};
            c_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_exec_unit
//  Description : RV32I execute stage - immediate decode, ALU, branch compare,
//                with a registered copy of the ALU result and branch flag
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_exec_unit
    import rv32_exec_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] imm,
    output logic [31:0] result,
    output logic        take_b,
    output logic [31:0] result_q,
    output logic        take_b_q
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_alt;
    logic [4:0]  w_shamt;
    logic        w_lt_s;
    logic        w_lt_u;
    logic [31:0] w_result;
    logic        w_take_b;
    logic [31:0] r_result_q;
    logic        r_take_b_q;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_alt    = inst[30];
    assign w_shamt  = in_b[4:0];
    assign w_lt_s   = ($signed(in_a) < $signed(in_b));
    assign w_lt_u   = (in_a < in_b);

    rv32_imm_decode u_imm_decode (
        .inst (inst),
        .imm  (imm)
    );

    // ALU: funct3 ops for OP/OP-IMM, plain add for every other opcode (address/link math)
    always_comb begin
        w_result = in_a + in_b;
        if ((w_opcode == c_OP) || (w_opcode == c_OP_IMM)) begin
            case (w_funct3)
                c_F3_ADD:  w_result = ((w_opcode == c_OP) && w_alt) ? (in_a - in_b) : (in_a + in_b);
                c_F3_SLL:  w_result = in_a << w_shamt;
                c_F3_SLT:  w_result = {31'd0, w_lt_s};
                c_F3_SLTU: w_result = {31'd0, w_lt_u};
                c_F3_XOR:  w_result = in_a ^ in_b;
                c_F3_SR:   w_result = w_alt ? $unsigned($signed(in_a) >>> w_shamt) : (in_a >> w_shamt);
                c_F3_OR:   w_result = in_a | in_b;
                c_F3_AND:  w_result = in_a & in_b;
                default:   w_result = in_a + in_b;
            endcase
        end
    end

    // Branch condition evaluation; only BRANCH opcodes can raise the flag
    always_comb begin
        w_take_b = 1'b0;
        if (w_opcode == c_BRANCH) begin
            case (w_funct3)
                c_F3_BEQ:  w_take_b = (in_a == in_b);
                c_F3_BNE:  w_take_b = (in_a != in_b);
                c_F3_BLT:  w_take_b = w_lt_s;
                c_F3_BGE:  w_take_b = ~w_lt_s;
                c_F3_BLTU: w_take_b = w_lt_u;
                c_F3_BGEU: w_take_b = ~w_lt_u;
                default:   w_take_b = 1'b0;
            endcase
        end
    end

    // One-cycle registered copy; reset wins over fresh data on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result_q <= 32'h0000_0000;
            r_take_b_q <= 1'b0;
        end else begin
            r_result_q <= w_result;
            r_take_b_q <= w_take_b;
        end
    end

    assign result   = w_result;
    assign take_b   = w_take_b;
    assign result_q = r_result_q;
    assign take_b_q = r_take_b_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_exec_unit
//  Description : Directed self-checking bench for rv32_exec_unit
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_exec_unit;

    logic        clk;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] imm;
    logic [31:0] result;
    logic        take_b;
    logic [31:0] result_q;
    logic        take_b_q;

    int total;
    int bad;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    rv32_exec_unit dut (
        .clk      (clk),
        .reset    (reset),
        .inst     (inst),
        .in_a     (in_a),
        .in_b     (in_b),
        .imm      (imm),
        .result   (result),
        .take_b   (take_b),
        .result_q (result_q),
        .take_b_q (take_b_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic alt);
        return {1'b0, alt, 5'd0, 5'd0, 5'd0, f3, 5'd0, op};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        inst = i;
        in_a = a;
        in_b = b;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(mk(OPC_OP, 3'b000, 1'b0), 32'd7, 32'd9);
        @(posedge clk); #1;
        total++;
        if (result_q !== 32'h0) begin bad++; $display("FAIL reset_result_q got=%h exp=%h", result_q, 32'h0); end
        total++;
        if (take_b_q !== 1'b0) begin bad++; $display("FAIL reset_take_b_q got=%b exp=0", take_b_q); end
        total++;
        if (result !== 32'd16) begin bad++; $display("FAIL reset_comb_result got=%h exp=%h", result, 32'd16); end
        reset = 1'b0;
    endtask

    task automatic test_add_sub();
        drive(mk(OPC_OP, 3'b000, 1'b0), 32'hFFFF_FFFF, 32'd1);
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL add_wrap got=%h exp=%h", result, 32'h0); end
        drive(mk(OPC_OP, 3'b000, 1'b1), 32'h0, 32'd1);
        total++;
        if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub got=%h exp=%h", result, 32'hFFFF_FFFF); end
        // OP-IMM never subtracts even with inst[30] set
        drive(mk(OPC_OP_IMM, 3'b000, 1'b1), 32'd5, 32'd3);
        total++;
        if (result !== 32'd8) begin bad++; $display("FAIL addi_alt got=%h exp=%h", result, 32'd8); end
    endtask

    task automatic test_shifts();
        drive(mk(OPC_OP_IMM, 3'b101, 1'b1), 32'h8000_0000, 32'h404);
        total++;
        if (result !== 32'hF800_0000) begin bad++; $display("FAIL srai got=%h exp=%h", result, 32'hF800_0000); end
        drive(mk(OPC_OP_IMM, 3'b101, 1'b0), 32'h8000_0000, 32'h404);
        total++;
        if (result !== 32'h0800_0000) begin bad++; $display("FAIL srli got=%h exp=%h", result, 32'h0800_0000); end
        drive(mk(OPC_OP, 3'b001, 1'b0), 32'h0000_0003, 32'h0000_0021);
        total++;
        if (result !== 32'h0000_0006) begin bad++; $display("FAIL sll_shamt5 got=%h exp=%h", result, 32'h6); end
        drive(mk(OPC_OP, 3'b101, 1'b1), 32'h8000_0000, 32'd31);
        total++;
        if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sra31 got=%h exp=%h", result, 32'hFFFF_FFFF); end
    endtask

    task automatic test_logic();
        drive(mk(OPC_OP, 3'b100, 1'b0), 32'hF0F0_1234, 32'h0FF0_00FF);
        total++;
        if (result !== 32'hFF00_12CB) begin bad++; $display("FAIL xor got=%h exp=%h", result, 32'hFF00_12CB); end
        drive(mk(OPC_OP, 3'b110, 1'b0), 32'hF0F0_1234, 32'h0FF0_00FF);
        total++;
        if (result !== 32'hFFF0_12FF) begin bad++; $display("FAIL or got=%h exp=%h", result, 32'hFFF0_12FF); end
        drive(mk(OPC_OP, 3'b111, 1'b0), 32'hF0F0_1234, 32'h0FF0_00FF);
        total++;
        if (result !== 32'h00F0_0034) begin bad++; $display("FAIL and got=%h exp=%h", result, 32'h00F0_0034); end
    endtask

    task automatic test_compare();
        drive(mk(OPC_OP, 3'b010, 1'b0), 32'hFFFF_FFFF, 32'd1);
        total++;
        if (result !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=%h", result, 32'd1); end
        drive(mk(OPC_OP, 3'b011, 1'b0), 32'hFFFF_FFFF, 32'd1);
        total++;
        if (result !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=%h", result, 32'd0); end
        drive(mk(OPC_OP_IMM, 3'b010, 1'b0), 32'h8000_0000, 32'h7FFF_FFFF);
        total++;
        if (result !== 32'd1) begin bad++; $display("FAIL slti_minneg got=%h exp=%h", result, 32'd1); end
    endtask

    task automatic test_branch();
        drive(mk(OPC_BRANCH, 3'b100, 1'b0), 32'hFFFF_FFFF, 32'd1);
        total++;
        if (take_b !== 1'b1) begin bad++; $display("FAIL blt got=%b exp=1", take_b); end
        drive(mk(OPC_BRANCH, 3'b111, 1'b0), 32'hFFFF_FFFF, 32'd1);
        total++;
        if (take_b !== 1'b1) begin bad++; $display("FAIL bgeu got=%b exp=1", take_b); end
        drive(mk(OPC_BRANCH, 3'b000, 1'b0), 32'd5, 32'd5);
        total++;
        if (take_b !== 1'b1) begin bad++; $display("FAIL beq got=%b exp=1", take_b); end
        drive(mk(OPC_BRANCH, 3'b001, 1'b0), 32'd5, 32'd5);
        total++;
        if (take_b !== 1'b0) begin bad++; $display("FAIL bne got=%b exp=0", take_b); end
        drive(mk(OPC_BRANCH, 3'b010, 1'b0), 32'd5, 32'd5);
        total++;
        if (take_b !== 1'b0) begin bad++; $display("FAIL b010 got=%b exp=0", take_b); end
        drive(mk(OPC_BRANCH, 3'b011, 1'b0), 32'd1, 32'd2);
        total++;
        if (take_b !== 1'b0) begin bad++; $display("FAIL b011 got=%b exp=0", take_b); end
        drive(mk(OPC_BRANCH, 3'b101, 1'b0), 32'h8000_0000, 32'h7FFF_FFFF);
        total++;
        if (take_b !== 1'b0) begin bad++; $display("FAIL bge_minneg got=%b exp=0", take_b); end
        drive(mk(OPC_BRANCH, 3'b110, 1'b0), 32'd1, 32'd2);
        total++;
        if (take_b !== 1'b1) begin bad++; $display("FAIL bltu got=%b exp=1", take_b); end
        drive(mk(OPC_BRANCH, 3'b000, 1'b0), 32'd5, 32'd6);
        total++;
        if (take_b !== 1'b0) begin bad++; $display("FAIL beq_ne got=%b exp=0", take_b); end
        total++;
        if (result !== 32'd11) begin bad++; $display("FAIL branch_add got=%h exp=%h", result, 32'd11); end
    endtask

    task automatic test_imm();
        drive(32'hFE00_0EE3, 32'd0, 32'd0);
        total++;
        if (imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_b got=%h exp=%h", imm, 32'hFFFF_FFFC); end
        drive(32'h8000_00EF, 32'd0, 32'd0);
        total++;
        if (imm !== 32'hFFF0_0000) begin bad++; $display("FAIL imm_j got=%h exp=%h", imm, 32'hFFF0_0000); end
        drive(32'h1234_52B7, 32'd0, 32'd0);
        total++;
        if (imm !== 32'h1234_5000) begin bad++; $display("FAIL imm_u got=%h exp=%h", imm, 32'h1234_5000); end
        drive(32'hFE11_2E23, 32'd0, 32'd0);
        total++;
        if (imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_s got=%h exp=%h", imm, 32'hFFFF_FFFC); end
        // addi x1, x0, -1
        drive(32'hFFF0_0093, 32'd0, 32'd0);
        total++;
        if (imm !== 32'hFFFF_FFFF) begin bad++; $display("FAIL imm_i got=%h exp=%h", imm, 32'hFFFF_FFFF); end
        // addi x1, x0, 0x7FF
        drive(32'h7FF0_0093, 32'd0, 32'd0);
        total++;
        if (imm !== 32'h0000_07FF) begin bad++; $display("FAIL imm_i_pos got=%h exp=%h", imm, 32'h7FF); end
        // J-type with every immediate field set positive: imm = 0x000FFFFE
        drive(32'h7FFF_F06F, 32'd0, 32'd0);
        total++;
        if (imm !== 32'h000F_FFFE) begin bad++; $display("FAIL imm_j_pos got=%h exp=%h", imm, 32'h000F_FFFE); end
        drive(32'hFFFF_FFB3 & 32'hFFFF_FF80 | 32'h0000_0000 | 32'h0000_0073, 32'd0, 32'd0);
        total++;
        if (imm !== 32'h0) begin bad++; $display("FAIL imm_system got=%h exp=%h", imm, 32'h0); end
    endtask

    task automatic test_nonbranch();
        drive(mk(OPC_JALR, 3'b000, 1'b0), 32'h100, 32'd4);
        total++;
        if (result !== 32'h104) begin bad++; $display("FAIL jalr_result got=%h exp=%h", result, 32'h104); end
        total++;
        if (take_b !== 1'b0) begin bad++; $display("FAIL jalr_take_b got=%b exp=0", take_b); end
        drive(mk(OPC_SYSTEM, 3'b000, 1'b0), 32'd5, 32'd5);
        total++;
        if (take_b !== 1'b0) begin bad++; $display("FAIL system_take_b got=%b exp=0", take_b); end
        // SYSTEM with a funct3 that would be SLT under OP must still add
        drive(mk(OPC_SYSTEM, 3'b010, 1'b1), 32'hFFFF_FFFF, 32'd2);
        total++;
        if (result !== 32'd1) begin bad++; $display("FAIL system_add got=%h exp=%h", result, 32'd1); end
    endtask

    task automatic test_registered();
        @(negedge clk);
        drive(mk(OPC_OP, 3'b000, 1'b0), 32'd2, 32'd3);
        @(posedge clk); #1;
        total++;
        if (result_q !== 32'd5) begin bad++; $display("FAIL reg_add got=%h exp=%h", result_q, 32'd5); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (result_q !== 32'd0) begin bad++; $display("FAIL reg_reset_result got=%h exp=%h", result_q, 32'd0); end
        total++;
        if (take_b_q !== 1'b0) begin bad++; $display("FAIL reg_reset_take got=%b exp=0", take_b_q); end
        total++;
        if (result !== 32'd5) begin bad++; $display("FAIL reg_reset_comb got=%h exp=%h", result, 32'd5); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        // cycle 1: BEQ 5,5 -> take_b_q=1, result_q=10
        @(negedge clk);
        drive(mk(OPC_BRANCH, 3'b000, 1'b0), 32'd5, 32'd5);
        @(posedge clk); #1;
        total++;
        if (take_b_q !== 1'b1) begin bad++; $display("FAIL b2b_take1 got=%b exp=1", take_b_q); end
        total++;
        if (result_q !== 32'd10) begin bad++; $display("FAIL b2b_res1 got=%h exp=%h", result_q, 32'd10); end
        // cycle 2: SUB 10-3 -> result_q=7, take_b_q=0
        drive(mk(OPC_OP, 3'b000, 1'b1), 32'd10, 32'd3);
        @(posedge clk); #1;
        total++;
        if (take_b_q !== 1'b0) begin bad++; $display("FAIL b2b_take2 got=%b exp=0", take_b_q); end
        total++;
        if (result_q !== 32'd7) begin bad++; $display("FAIL b2b_res2 got=%h exp=%h", result_q, 32'd7); end
        // cycle 3: BNE 1,2 while reset is high -> registers cleared
        drive(mk(OPC_BRANCH, 3'b001, 1'b0), 32'd1, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (take_b_q !== 1'b0) begin bad++; $display("FAIL b2b_take3 got=%b exp=0", take_b_q); end
        total++;
        if (take_b !== 1'b1) begin bad++; $display("FAIL b2b_comb3 got=%b exp=1", take_b); end
        reset = 1'b0;
        // cycle 4: same BNE without reset -> take_b_q=1
        @(posedge clk); #1;
        total++;
        if (take_b_q !== 1'b1) begin bad++; $display("FAIL b2b_take4 got=%b exp=1", take_b_q); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        inst  = 32'h0;
        in_a  = 32'h0;
        in_b  = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_add_sub();
        test_shifts();
        test_logic();
        test_compare();
        test_branch();
        test_imm();
        test_nonbranch();
        test_registered();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_exec_unit.md
RV32_EXEC_UNIT -- requirements
Module: rv32_exec_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
REQ-003 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `inst`: input, 32 bits, RV32I instruction word in execute.
REQ-005 Port `in_a`: input, 32 bits, ALU operand A (rs1 or PC, chosen upstream).
REQ-006 Port `in_b`: input, 32 bits, ALU operand B (rs2, immediate or 4, chosen upstream).
REQ-007 Port `imm`: output, 32 bits, combinational decoded immediate of `inst`.
REQ-008 Port `result`: output, 32 bits, combinational ALU result.
REQ-009 Port `take_b`: output, 1 bit, combinational branch-taken flag.
REQ-010 Port `result_q`: output, 32 bits, `result` registered on `clk`.
REQ-011 Port `take_b_q`: output, 1 bit, `take_b` registered on `clk`.

Function
REQ-012 The block SHALL decode opcode = `inst[6:0]`, funct3 = `inst[14:12]` and alt = `inst[30]`.
REQ-013 Immediates SHALL be formed as follows, always sign-extended from `inst[31]`:
- I-type (opcodes 0000011, 0010011, 1100111): `inst[31:20]`.
- S-type (0100011): {`inst[31:25]`, `inst[11:7]`}.
- B-type (1100011): {`inst[31]`, `inst[7]`, `inst[30:25]`, `inst[11:8]`, 0}.
- U-type (0110111, 0010111): {`inst[31:12]`, 12 zeros}.
- J-type (1101111): {`inst[31]`, `inst[19:12]`, `inst[20]`, `inst[30:21]`, 0}.
REQ-014 `imm` SHALL be 0 for any other opcode.
REQ-015 For OP (0110011) and OP-IMM (0010011), `result` SHALL depend on funct3:
- 000: ADD; SUB only when OP and alt=1.
- 001: SLL.
- 010: SLT (signed, 1/0).
- 011: SLTU (1/0).
- 100: XOR.
- 101: SRL, or SRA when alt=1 (applies to both OP and OP-IMM).
- 110: OR.
- 111: AND.
REQ-016 Shift amount SHALL be `in_b[4:0]` only.
REQ-017 For all other opcodes (LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, SYSTEM, unknown), `result` SHALL be `in_a` + `in_b`, modulo 2^32.
REQ-018 For BRANCH, `take_b` SHALL depend on funct3:
- 000: `in_a` == `in_b`.
- 001: `in_a` != `in_b`.
- 100: signed `in_a` < `in_b`.
- 101: signed `in_a` >= `in_b`.
- 110: unsigned `in_a` < `in_b`.
- 111: unsigned `in_a` >= `in_b`.
- 010 and 011: 0.
REQ-019 `take_b` SHALL be 0 for every non-BRANCH opcode.
REQ-020 All arithmetic SHALL be 32-bit wrap-around with no overflow flag; signed compare SHALL treat 0x80000000 as the most negative value.
REQ-021 `imm`, `result` and `take_b` SHALL be purely combinational (zero latency).
REQ-022 `result_q` and `take_b_q` SHALL update every rising `clk` edge with one-cycle latency.
REQ-023 The block SHALL have no handshake and no stall input.

Reset
REQ-024 While `reset`=1 at a rising edge, `result_q` SHALL load 0 and `take_b_q` SHALL load 0.
REQ-025 Reset SHALL NOT affect the combinational outputs.
REQ-026 Reset asserted mid-stream SHALL take priority over new data on that edge.

Structure
REQ-027 A shared package SHALL hold the opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM) and the funct3 constants for ALU and branch operations.
REQ-028 Immediate decode SHALL be one sub-module, `rv32_imm_decode` (input `inst`, output `imm`).
REQ-029 ALU and branch logic SHALL reside in the top level.

Verification
REQ-030 ADD/SUB: OP funct3=000 alt=0, `in_a`=0xFFFFFFFF, `in_b`=1 -> `result`=0x00000000; same with alt=1, `in_a`=0, `in_b`=1 -> `result`=0xFFFFFFFF.
REQ-031 Shifts: OP-IMM funct3=101 alt=1, `in_a`=0x80000000, `in_b`=0x404 -> `result`=0xF8000000; same with alt=0 -> `result`=0x08000000.
REQ-032 Compares: SLT `in_a`=0xFFFFFFFF, `in_b`=1 -> `result`=1; SLTU same operands -> `result`=0; BLT same operands -> `take_b`=1; BGEU -> `take_b`=1; BEQ 5,5 -> 1; BNE 5,5 -> 0; funct3=010 -> 0.
REQ-033 Immediates: `inst`=0xFE000EE3 (B-type, imm=-4) -> `imm`=0xFFFFFFFC; `inst`=0x800000EF (JAL) -> `imm`=0xFFF00000; `inst`=0x123452B7 (LUI) -> `imm`=0x12345000; `inst`=0xFE112E23 (SW) -> `imm`=0xFFFFFFFC.
REQ-034 Non-branch: JALR `in_a`=0x100, `in_b`=4 -> `result`=0x104, `take_b`=0; SYSTEM opcode -> `take_b`=0.
REQ-035 Registered path: drive ADD 2+3 -> `result_q`=5 after one edge; assert `reset` -> `result_q`=0 and `take_b_q`=0 on the next edge while `result` stays 5.
